// File: rtl/lsu_store_buffer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | lsu_store_buffer: in-order store queue with commit/squash, per-byte     |
// | load forwarding and drain. Option: SB_DRAIN_COALESCE_EN. Revision: 1.0  |
// +------------------------------------------------------------------------+
module lsu_store_buffer #(
  parameter int DEPTH       = 8,
  parameter int XLEN        = 64,
  parameter int NR_LD_PORTS = 2,
  parameter int ID_W        = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  push_valid,
  output logic                                  push_ready,
  input  logic [ID_W-1:0]                       push_id,
  input  logic [XLEN-1:0]                       push_addr,
  input  logic [XLEN-1:0]                       push_data,
  input  logic [XLEN/8-1:0]                     push_mask,
  input  logic                                  commit_valid,
  input  logic                                  squash_valid,
  output logic                                  drain_valid,
  input  logic                                  drain_ready,
  output logic [XLEN-1:0]                       drain_addr,
  output logic [XLEN-1:0]                       drain_data,
  output logic [XLEN/8-1:0]                     drain_mask,
  input  logic [NR_LD_PORTS-1:0]                ld_valid,
  input  logic [NR_LD_PORTS-1:0][ID_W-1:0]      ld_id,
  input  logic [NR_LD_PORTS-1:0][XLEN-1:0]      ld_addr,
  input  logic [NR_LD_PORTS-1:0][XLEN/8-1:0]    ld_mask,
  output logic [NR_LD_PORTS-1:0][XLEN/8-1:0]    fw_mask,
  output logic [NR_LD_PORTS-1:0][XLEN-1:0]      fw_data,
  output logic [NR_LD_PORTS-1:0]                fw_full,
  output logic [$clog2(DEPTH):0]                count,
  output logic                                  empty
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam int c_NB = XLEN / 8;
  localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);
  localparam logic [c_PW-1:0] c_PTR_ONE   = c_PW'(1);
  localparam logic [ID_W-1:0] c_ID_HALF   = {1'b1, {(ID_W-1){1'b0}}};

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_committed;
  logic [ID_W-1:0]  r_id   [DEPTH];
  logic [XLEN-1:0]  r_addr [DEPTH];
  logic [XLEN-1:0]  r_data [DEPTH];
  logic [c_NB-1:0]  r_mask [DEPTH];
  logic [c_PW-1:0]  r_head, r_cmt, r_tail;
  logic [c_CW-1:0]  r_count;

  logic             w_push, w_commit, w_drain_hs, w_coal;
  logic [c_PW-1:0]  w_h1, w_cmt_next, w_head_next;
  logic [c_CW-1:0]  w_drain_n, w_sq_n, w_count_next;
  logic [DEPTH-1:0] w_sq_vec;

  assign push_ready = !rst && (r_count < c_DEPTH_CNT) && !squash_valid;
  assign w_push     = push_valid && push_ready;
  // cmt points at a valid-but-uncommitted entry only when one exists
  assign w_commit   = commit_valid && r_valid[r_cmt] && !r_committed[r_cmt];
  assign w_cmt_next = w_commit ? r_cmt + c_PTR_ONE : r_cmt;

  assign drain_valid = r_valid[r_head] && r_committed[r_head];
  assign w_drain_hs  = drain_valid && drain_ready;
  assign w_h1        = r_head + c_PTR_ONE;

`ifdef SB_DRAIN_COALESCE_EN
  assign w_coal = drain_valid && r_valid[w_h1] && r_committed[w_h1] &&
                  (r_addr[w_h1][XLEN-1:3] == r_addr[r_head][XLEN-1:3]);
`else
  assign w_coal = 1'b0;
`endif

  assign w_drain_n   = w_drain_hs ? (w_coal ? c_CW'(2) : c_CW'(1)) : '0;
  assign w_head_next = r_head + w_drain_n[c_PW-1:0];
  assign drain_addr  = r_addr[r_head];

  always_comb begin
    drain_mask = r_mask[r_head];
    drain_data = r_data[r_head];
    if (w_coal) begin
      drain_mask = drain_mask | r_mask[w_h1];
      for (int b = 0; b < c_NB; b++) begin
        if (r_mask[w_h1][b]) drain_data[8*b +: 8] = r_data[w_h1][8*b +: 8];
      end
    end
  end

  // Entries killed by a squash: uncommitted ones, sparing any committed this cycle
  always_comb begin
    w_sq_vec = '0;
    w_sq_n   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (squash_valid && r_valid[i] && !r_committed[i] &&
          !(w_commit && (r_cmt == c_PW'(i)))) begin
        w_sq_vec[i] = 1'b1;
        w_sq_n      = w_sq_n + c_CW'(1);
      end
    end
  end

  assign w_count_next = r_count + (w_push ? c_CW'(1) : '0) - w_drain_n - w_sq_n;
  assign count = r_count;
  assign empty = (r_count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= '0;
      r_committed <= '0;
      r_head      <= '0;
      r_cmt       <= '0;
      r_tail      <= '0;
      r_count     <= '0;
    end else begin
      if (w_push) begin
        r_valid[r_tail]     <= 1'b1;
        r_committed[r_tail] <= 1'b0;
      end
      if (w_commit) r_committed[r_cmt] <= 1'b1;
      if (w_drain_hs) begin
        r_valid[r_head]     <= 1'b0;
        r_committed[r_head] <= 1'b0;
        if (w_coal) begin
          r_valid[w_h1]     <= 1'b0;
          r_committed[w_h1] <= 1'b0;
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (w_sq_vec[i]) r_valid[i] <= 1'b0;
      end
      r_head  <= w_head_next;
      r_cmt   <= w_cmt_next;
      r_tail  <= squash_valid ? w_cmt_next : (w_push ? r_tail + c_PTR_ONE : r_tail);
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_id[r_tail]   <= push_id;
      r_addr[r_tail] <= push_addr;
      r_data[r_tail] <= push_data;
      r_mask[r_tail] <= push_mask;
    end
  end

  for (genvar p = 0; p < NR_LD_PORTS; p++) begin : g_ld_port
    logic [c_PW-1:0] w_idx;
    logic [ID_W-1:0] w_diff;
    logic [c_NB-1:0] w_fw_mask;
    logic [XLEN-1:0] w_fw_data;
    logic            w_unused_ld_lo;

    assign w_unused_ld_lo = ^ld_addr[p][2:0];

    // Walk oldest to youngest so younger stores overwrite older bytes
    always_comb begin
      w_idx     = r_head;
      w_diff    = '0;
      w_fw_mask = '0;
      w_fw_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
        w_idx  = r_head + c_PW'(k);
        w_diff = ld_id[p] - r_id[w_idx];
        if (r_valid[w_idx] &&
            (r_committed[w_idx] || ((w_diff != '0) && (w_diff < c_ID_HALF))) &&
            (r_addr[w_idx][XLEN-1:3] == ld_addr[p][XLEN-1:3])) begin
          for (int b = 0; b < c_NB; b++) begin
            if (r_mask[w_idx][b]) begin
              w_fw_mask[b]         = 1'b1;
              w_fw_data[8*b +: 8]  = r_data[w_idx][8*b +: 8];
            end
          end
        end
      end
      for (int b = 0; b < c_NB; b++) begin
        if (!(ld_valid[p] && ld_mask[p][b])) begin
          w_fw_mask[b]        = 1'b0;
          w_fw_data[8*b +: 8] = 8'h00;
        end
      end
    end

    assign fw_mask[p] = w_fw_mask;
    assign fw_data[p] = w_fw_data;
    assign fw_full[p] = ld_valid[p] && (w_fw_mask == ld_mask[p]) && (ld_mask[p] != '0);
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_store_buffer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_lsu_store_buffer: directed + random bench against a queue model.     |
// | Honours SB_DRAIN_COALESCE_EN. Revision: 1.0                             |
// +------------------------------------------------------------------------+
module tb_lsu_store_buffer;
  localparam int DEPTH = 8;
  localparam int XLEN  = 64;
  localparam int NR    = 2;
  localparam int ID_W  = 8;
  localparam int NB    = XLEN / 8;

  logic                     clk, rst;
  logic                     push_valid, push_ready;
  logic [ID_W-1:0]          push_id;
  logic [XLEN-1:0]          push_addr, push_data;
  logic [NB-1:0]            push_mask;
  logic                     commit_valid, squash_valid;
  logic                     drain_valid, drain_ready;
  logic [XLEN-1:0]          drain_addr, drain_data;
  logic [NB-1:0]            drain_mask;
  logic [NR-1:0]            ld_valid;
  logic [NR-1:0][ID_W-1:0]  ld_id;
  logic [NR-1:0][XLEN-1:0]  ld_addr;
  logic [NR-1:0][NB-1:0]    ld_mask;
  logic [NR-1:0][NB-1:0]    fw_mask;
  logic [NR-1:0][XLEN-1:0]  fw_data;
  logic [NR-1:0]            fw_full;
  logic [$clog2(DEPTH):0]   count;
  logic                     empty;

  lsu_store_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .NR_LD_PORTS(NR), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_ready(push_ready), .push_id(push_id),
    .push_addr(push_addr), .push_data(push_data), .push_mask(push_mask),
    .commit_valid(commit_valid), .squash_valid(squash_valid),
    .drain_valid(drain_valid), .drain_ready(drain_ready), .drain_addr(drain_addr),
    .drain_data(drain_data), .drain_mask(drain_mask),
    .ld_valid(ld_valid), .ld_id(ld_id), .ld_addr(ld_addr), .ld_mask(ld_mask),
    .fw_mask(fw_mask), .fw_data(fw_data), .fw_full(fw_full),
    .count(count), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [ID_W-1:0] id;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [NB-1:0]   mask;
    bit              cmt;
  } ent_t;

  ent_t q[$];

  function automatic logic [XLEN-1:0] bytes_of(input logic [NB-1:0] m);
    logic [XLEN-1:0] r = '0;
    for (int b = 0; b < NB; b++) if (m[b]) r[8*b +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic bit is_older(input ent_t e, input logic [ID_W-1:0] lid);
    int d;
    d = int'(lid) - int'(e.id);
    if (d < 0) d += (1 << ID_W);
    return e.cmt || (d >= 1 && d < (1 << (ID_W - 1)));
  endfunction

  function automatic bit model_coal();
`ifdef SB_DRAIN_COALESCE_EN
    return q.size() >= 2 && q[0].cmt && q[1].cmt && q[0].addr[XLEN-1:3] == q[1].addr[XLEN-1:3];
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_fw(input int p, output logic [NB-1:0] m, output logic [XLEN-1:0] d);
    m = '0;
    d = '0;
    if (ld_valid[p]) begin
      foreach (q[i]) begin
        if (is_older(q[i], ld_id[p]) && q[i].addr[XLEN-1:3] == ld_addr[p][XLEN-1:3]) begin
          for (int b = 0; b < NB; b++) begin
            if (q[i].mask[b]) begin
              m[b] = 1'b1;
              d[8*b +: 8] = q[i].data[8*b +: 8];
            end
          end
        end
      end
      m = m & ld_mask[p];
      d = d & bytes_of(m);
    end
  endtask

  task automatic compare_outputs();
    bit              exp_pr, exp_dv;
    logic [NB-1:0]   em;
    logic [XLEN-1:0] ed;
    exp_pr = (q.size() < DEPTH) && !squash_valid;
    check("push_ready", push_ready, exp_pr);
    exp_dv = (q.size() > 0) && q[0].cmt;
    check("drain_valid", drain_valid, exp_dv);
    if (exp_dv) begin
      em = q[0].mask;
      ed = q[0].data;
      if (model_coal()) begin
        for (int b = 0; b < NB; b++) if (q[1].mask[b]) ed[8*b +: 8] = q[1].data[8*b +: 8];
        em = em | q[1].mask;
      end
      check("drain_addr", drain_addr, q[0].addr);
      check("drain_mask", drain_mask, em);
      check("drain_data", drain_data & bytes_of(em), ed & bytes_of(em));
    end
    check("count", count, q.size());
    check("empty", empty, q.size() == 0);
    for (int p = 0; p < NR; p++) begin
      model_fw(p, em, ed);
      check("fw_mask", fw_mask[p], em);
      check("fw_data", fw_data[p], ed);
      check("fw_full", fw_full[p], ld_valid[p] && em == ld_mask[p] && ld_mask[p] != '0);
    end
  endtask

  task automatic model_update();
    bit   pr;
    int   nd;
    ent_t e;
    pr = (q.size() < DEPTH) && !squash_valid;
    nd = 0;
    if (drain_ready && q.size() > 0 && q[0].cmt) nd = model_coal() ? 2 : 1;
    if (commit_valid) begin
      for (int i = 0; i < q.size(); i++) begin
        if (!q[i].cmt) begin
          q[i].cmt = 1'b1;
          break;
        end
      end
    end
    repeat (nd) q.delete(0);
    if (squash_valid) begin
      while (q.size() > 0 && !q[q.size()-1].cmt) q.delete(q.size()-1);
    end else if (push_valid && pr) begin
      e.id = push_id; e.addr = push_addr; e.data = push_data; e.mask = push_mask; e.cmt = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic step();
    #1;
    compare_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    push_valid = 0; push_id = '0; push_addr = '0; push_data = '0; push_mask = '0;
    commit_valid = 0; squash_valid = 0; drain_ready = 0;
    ld_valid = '0; ld_id = '0; ld_addr = '0; ld_mask = '0;
  endtask

  task automatic push_store(input logic [ID_W-1:0] id, input logic [XLEN-1:0] a,
                            input logic [XLEN-1:0] d, input logic [NB-1:0] m);
    push_valid = 1; push_id = id; push_addr = a; push_data = d; push_mask = m;
    step();
    push_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    check("rst_push_ready", push_ready, 0);
    check("rst_drain_valid", drain_valid, 0);
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    check("post_rst_ready", push_ready, !squash_valid);
  endtask

  task automatic drain_all();
    push_valid = 0; squash_valid = 0; commit_valid = 1; drain_ready = 1;
    for (int i = 0; i < 40 && q.size() > 0; i++) step();
    commit_valid = 0; drain_ready = 0;
    #1;
    check("drain_all_empty", empty, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [ID_W-1:0] next_id;
  logic [XLEN-1:0] bases [4];

  initial begin
    rst = 1;
    clr_inputs();
    @(negedge clk);
    do_reset();

    // Fill with uncommitted stores, drain must stay blocked
    drain_ready = 1;
    for (int i = 1; i <= 8; i++) push_store(ID_W'(i), 64'h1000 + 64'(8 * i), 64'(i * 64'h0101), 8'hFF);
    #1;
    check("full_count", count, 8);
    check("full_push_ready", push_ready, 0);
    check("full_drain_blocked", drain_valid, 0);
    step(); step();
    drain_all();

    // Youngest-older store wins per byte
    push_store(8'd3, 64'h100, 64'h44332211, 8'h0F);
    push_store(8'd5, 64'h100, 64'h0000AAAA, 8'h03);
    ld_valid = 2'b11;
    ld_id[0] = 8'd6; ld_addr[0] = 64'h100; ld_mask[0] = 8'h0F;
    ld_id[1] = 8'd4; ld_addr[1] = 64'h100; ld_mask[1] = 8'h0F;
    #1;
    check("fwd_id6_data", fw_data[0], 64'h4433AAAA);
    check("fwd_id6_full", fw_full[0], 1);
    check("fwd_id4_data", fw_data[1], 64'h44332211);
    check("fwd_id4_mask", fw_mask[1], 8'h0F);
    step();
    ld_id[1] = 8'd2;
    #1;
    check("fwd_id2_mask", fw_mask[1], 8'h00);
    check("fwd_id2_full", fw_full[1], 0);
    step();
    ld_valid = '0;
    squash_valid = 1; step(); squash_valid = 0;

    // Squash with a same-cycle push after two commits
    for (int i = 0; i < 4; i++) push_store(ID_W'(10 + i), 64'h100 + 64'(8 * i), 64'hFFFF_0000 + 64'(i), 8'hFF);
    commit_valid = 1; step(); step(); commit_valid = 0;
    squash_valid = 1;
    push_valid = 1; push_id = 8'd14; push_addr = 64'h300; push_data = 64'h5555; push_mask = 8'hFF;
    step();
    squash_valid = 0; push_valid = 0;
    ld_valid = 2'b01; ld_id[0] = 8'd20; ld_addr[0] = 64'h300; ld_mask[0] = 8'hFF;
    #1;
    check("squash_count", count, 2);
    check("squash_push_absent", fw_mask[0], 8'h00);
    step();
    ld_valid = '0;
    push_store(8'd15, 64'h308, 64'h77, 8'h01);
    drain_all();

    // Id wraparound
    push_store(8'hFE, 64'h180, 64'h11, 8'h01);
    push_store(8'hFF, 64'h180, 64'h2200, 8'h02);
    push_store(8'h00, 64'h180, 64'h330000, 8'h04);
    ld_valid = 2'b01; ld_id[0] = 8'h01; ld_addr[0] = 64'h180; ld_mask[0] = 8'h07;
    #1;
    check("wrap_mask", fw_mask[0], 8'h07);
    check("wrap_data", fw_data[0], 64'h332211);
    check("wrap_full", fw_full[0], 1);
    step();
    ld_valid = '0;
    squash_valid = 1; step(); squash_valid = 0;

    // Two committed stores to the same doubleword
    push_store(8'h30, 64'h200, 64'hDDCCBBAA, 8'h0F);
    push_store(8'h31, 64'h200, 64'h44332211_00000000, 8'hF0);
    commit_valid = 1; step(); step(); commit_valid = 0;
    #1;
    check("coal_drain_valid", drain_valid, 1);
`ifdef SB_DRAIN_COALESCE_EN
    check("coal_mask", drain_mask, 8'hFF);
    check("coal_data", drain_data, 64'h44332211_DDCCBBAA);
`else
    check("single_mask", drain_mask, 8'h0F);
`endif
    drain_ready = 1; step(); drain_ready = 0;
    #1;
`ifdef SB_DRAIN_COALESCE_EN
    check("coal_count", count, 0);
`else
    check("single_count", count, 1);
`endif
    drain_all();

    // Randomised traffic
    bases[0] = 64'h100; bases[1] = 64'h108; bases[2] = 64'h200; bases[3] = 64'h2000;
    next_id = 8'h40;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        clr_inputs();
        do_reset();
      end
      push_valid   = ($urandom_range(0, 99) < 55);
      push_id      = next_id;
      push_addr    = bases[$urandom_range(0, 3)] | 64'($urandom_range(0, 7));
      push_data    = {$urandom, $urandom};
      push_mask    = NB'($urandom_range(1, 255));
      commit_valid = ($urandom_range(0, 99) < 40);
      squash_valid = ($urandom_range(0, 99) < 4);
      drain_ready  = ($urandom_range(0, 99) < 50);
      for (int p = 0; p < NR; p++) begin
        ld_valid[p] = ($urandom_range(0, 99) < 80);
        ld_id[p]    = next_id - ID_W'($urandom_range(0, 12));
        ld_addr[p]  = bases[$urandom_range(0, 3)] | 64'($urandom_range(0, 7));
        ld_mask[p]  = NB'($urandom_range(0, 255));
      end
      if (push_valid) next_id = next_id + 8'd1;
      step();
    end
    clr_inputs();
    drain_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
